// File: rtl/simple_pkg.sv
// Shared definitions for the SIMPLE core: instruction field positions, opcode
// constants, the phase encoding used by the sequencer, and the decode helper.
package simple_pkg;

  localparam int INSTR_W = 16;

  localparam int OP1_MSB = 15;
  localparam int OP1_LSB = 14;
  localparam int OP2_MSB = 13;
  localparam int OP2_LSB = 11;
  localparam int OP3_MSB = 7;
  localparam int OP3_LSB = 4;

  localparam logic [1:0] OP1_LD    = 2'b00;
  localparam logic [1:0] OP1_ST    = 2'b01;
  localparam logic [1:0] OP1_BR    = 2'b10;
  localparam logic [1:0] OP1_ALU   = 2'b11;
  localparam logic [2:0] OP2_BR    = 3'b100;
  localparam logic [2:0] OP2_BCOND = 3'b111;
  localparam logic [3:0] OP3_CMP   = 4'b0101;
  localparam logic [3:0] OP3_OUT   = 4'b1101;
  localparam logic [3:0] OP3_HLT   = 4'b1111;

  typedef enum logic [2:0] {
    PH_STOP,
    PH_P1,
    PH_P2,
    PH_P3,
    PH_P4,
    PH_P5
  } phase_t;

  typedef enum logic {
    MODE_RUN,
    MODE_STEP
  } mode_t;

  typedef struct packed {
    logic ld;
    logic st;
    logic br;
    logic hlt;
  } dec_t;

  function automatic logic [4:0] phase_onehot(phase_t ph);
    case (ph)
      PH_P1:   return 5'b00001;
      PH_P2:   return 5'b00010;
      PH_P3:   return 5'b00100;
      PH_P4:   return 5'b01000;
      PH_P5:   return 5'b10000;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic dec_t decode(logic [INSTR_W-1:0] instr);
    dec_t       d;
    logic [1:0] op1;
    logic [2:0] op2;
    logic [3:0] op3;
    op1   = instr[OP1_MSB:OP1_LSB];
    op2   = instr[OP2_MSB:OP2_LSB];
    op3   = instr[OP3_MSB:OP3_LSB];
    d.ld  = (op1 == OP1_LD);
    d.st  = (op1 == OP1_ST);
    d.br  = (op1 == OP1_BR) && ((op2 == OP2_BR) || (op2 == OP2_BCOND));
    d.hlt = (op1 == OP1_ALU) && (op3 == OP3_HLT);
    return d;
  endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Control bundle between the phase sequencer and the board/datapath around it.
// The slave side is the sequencer; the master side drives buttons and decode.
interface phase_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             exec;
  logic             step;
  logic [15:0]      instr;
  logic             dec_reg_write;
  logic             branch_taken;
  logic [4:0]       phase;
  logic             running;
  logic             halted;
  logic             pc_we;
  logic             ir_we;
  logic             rd_we;
  logic             alu_we;
  logic             br_we;
  logic             mem_we;
  logic             mdr_we;
  logic             reg_we;
  logic [CNT_W-1:0] retired;

  modport master (
    output exec, step, instr, dec_reg_write, branch_taken,
    input  phase, running, halted, pc_we, ir_we, rd_we, alu_we,
           br_we, mem_we, mdr_we, reg_we, retired
  );

  modport slave (
    input  exec, step, instr, dec_reg_write, branch_taken,
    output phase, running, halted, pc_we, ir_we, rd_we, alu_we,
           br_we, mem_we, mdr_we, reg_we, retired
  );
endinterface

// File: rtl/edge_detect.sv
// Registered rising-edge detector for a debounced button level; the pulse
// appears the cycle after the level is first sampled high.
module edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic rise
);
  logic prev_q;
  logic rise_q;

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      prev_q <= level;
      rise_q <= level & ~prev_q;
    end
  end

  assign rise = rise_q;
endmodule

// File: rtl/phase_sequencer.sv
// Five-phase instruction sequencer for the SIMPLE core: run/stop/step control,
// HLT handling, one-cycle datapath enables and a retired-instruction counter.
module phase_sequencer
  import simple_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic               clock,
  input logic               reset,
  phase_sequencer_if.slave  bus
);

  logic             exec_rise;
  logic             step_rise;
  phase_t           state_q, state_d;
  mode_t            mode_q, mode_d;
  logic             stop_req_q, stop_req_d;
  logic             halted_q, halted_d;
  dec_t             dec_q, dec_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             en_ok;

  edge_detect u_exec_edge (
    .clock (clock),
    .reset (reset),
    .level (bus.exec),
    .rise  (exec_rise)
  );

  edge_detect u_step_edge (
    .clock (clock),
    .reset (reset),
    .level (bus.step),
    .rise  (step_rise)
  );

  always_comb begin
    // NOTE: every next-state variable takes its hold value first, so no branch can infer a latch.
    state_d    = state_q;
    mode_d     = mode_q;
    stop_req_d = stop_req_q;
    halted_d   = halted_q;
    dec_d      = dec_q;
    retired_d  = retired_q;

    // Exec edges while sequencing toggle a pending stop; the instruction always completes.
    if (state_q != PH_STOP && exec_rise) begin
      stop_req_d = ~stop_req_q;
    end

    case (state_q)
      PH_STOP: begin
        stop_req_d = 1'b0;
        if (exec_rise) begin
          state_d  = PH_P1;
          mode_d   = MODE_RUN;
          halted_d = 1'b0;
        end else if (step_rise) begin
          state_d  = PH_P1;
          mode_d   = MODE_STEP;
          halted_d = 1'b0;
        end
      end
      PH_P1: state_d = PH_P2;
      PH_P2: begin
        state_d = PH_P3;
        dec_d   = decode(bus.instr);
      end
      PH_P3: state_d = PH_P4;
      PH_P4: state_d = PH_P5;
      PH_P5: begin
        retired_d = retired_q + CNT_W'(1);
        if (mode_q == MODE_STEP || stop_req_d || dec_q.hlt) begin
          state_d    = PH_STOP;
          stop_req_d = 1'b0;
          halted_d   = dec_q.hlt;
        end else begin
          state_d = PH_P1;
        end
      end
      default: state_d = PH_STOP;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= PH_STOP;
      mode_q     <= MODE_RUN;
      stop_req_q <= 1'b0;
      halted_q   <= 1'b0;
      dec_q      <= '0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      stop_req_q <= stop_req_d;
      halted_q   <= halted_d;
      dec_q      <= dec_d;
      retired_q  <= retired_d;
    end
  end

  // Reset suppresses every write enable in the cycle it is asserted.
  assign en_ok = !reset;

  assign bus.phase   = phase_onehot(state_q);
  assign bus.running = (state_q != PH_STOP);
  assign bus.halted  = halted_q;
  assign bus.retired = retired_q;

  assign bus.pc_we  = en_ok && (state_q == PH_P1);
  assign bus.ir_we  = en_ok && (state_q == PH_P1);
  assign bus.rd_we  = en_ok && (state_q == PH_P2);
  assign bus.alu_we = en_ok && (state_q == PH_P3);
  assign bus.br_we  = en_ok && (state_q == PH_P3) && dec_q.br && bus.branch_taken;
  assign bus.mem_we = en_ok && (state_q == PH_P4) && dec_q.st;
  assign bus.mdr_we = en_ok && (state_q == PH_P4) && dec_q.ld;
  assign bus.reg_we = en_ok && (state_q == PH_P5) && bus.dec_reg_write;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: each cycle's expected outputs are queued
// as stimulus is applied and compared against the DUT one cycle at a time.
module tb_phase_sequencer;

  // A narrow counter keeps the wrap-around reachable in a short run.
  localparam int CNT_W = 4;
  localparam int OBS_W = 15 + CNT_W;

  typedef struct {
    string            tag;
    logic [OBS_W-1:0] val;
  } exp_t;

  logic clk;
  logic reset;

  phase_sequencer_if #(.CNT_W(CNT_W)) bus ();

  phase_sequencer #(.CNT_W(CNT_W)) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  exp_t             exp_q[$];
  int               n_vec = 0;
  int               n_err = 0;
  logic             exp_halted;
  logic [CNT_W-1:0] exp_retired;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "bench timeout");
  end

  // Enable bit order: {pc, ir, rd, alu, br, mem, mdr, reg}.
  function automatic logic [7:0] std_en(int p);
    case (p)
      1:       return 8'hC0;
      2:       return 8'h20;
      3:       return 8'h10;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] slot_en(int p);
    case (p)
      3:       return 8'h08;
      4:       return 8'h06;
      5:       return 8'h01;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [OBS_W-1:0] mk(int p, logic [7:0] en);
    logic [4:0] oh;
    oh = (p == 0) ? 5'b00000 : 5'(1 << (p - 1));
    return {oh, (p != 0), exp_halted, en, exp_retired};
  endfunction

  function automatic logic [OBS_W-1:0] obs();
    return {bus.phase, bus.running, bus.halted, bus.pc_we, bus.ir_we, bus.rd_we,
            bus.alu_we, bus.br_we, bus.mem_we, bus.mdr_we, bus.reg_we, bus.retired};
  endfunction

  task automatic push(input string tag, input int p, input logic [7:0] en);
    exp_q.push_back('{tag: tag, val: mk(p, en)});
  endtask

  // Compare the current cycle against the oldest expectation, then advance a cycle.
  task automatic chk();
    exp_t             e;
    logic [OBS_W-1:0] o;
    #1;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: observed %h expected a queued entry", obs());
    end else begin
      e = exp_q.pop_front();
      o = obs();
      assert (o === e.val)
      else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", e.tag, o, e.val);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag, input int n);
    repeat (n) begin
      push(tag, 0, 8'h00);
      chk();
    end
  endtask

  task automatic start_exec();
    bus.exec = 1'b1;
    idle("start_exec", 1);
    bus.exec = 1'b0;
    idle("start_exec", 1);
  endtask

  task automatic start_step();
    bus.step = 1'b1;
    idle("start_step", 1);
    bus.step = 1'b0;
    idle("start_step", 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset       = 1'b0;
    exp_retired = '0;
    exp_halted  = 1'b0;
  endtask

  // One full instruction; extra lists the conditional enables expected in P3..P5.
  task automatic run_instr(input string tag, input logic [15:0] ins, input logic rw,
                           input logic bt, input logic [7:0] extra,
                           input logic [4:0] exec_pat, input logic [4:0] step_pat,
                           input logic hlt);
    bus.instr         = ins;
    bus.dec_reg_write = rw;
    bus.branch_taken  = bt;
    exp_halted        = 1'b0;
    for (int p = 1; p <= 5; p++) begin
      push($sformatf("%s.P%0d", tag, p), p, std_en(p) | (extra & slot_en(p)));
    end
    for (int p = 0; p < 5; p++) begin
      bus.exec = exec_pat[p];
      bus.step = step_pat[p];
      chk();
    end
    bus.exec    = 1'b0;
    bus.step    = 1'b0;
    exp_retired = exp_retired + CNT_W'(1);
    exp_halted  = hlt;
  endtask

  initial begin
    reset             = 1'b1;
    bus.exec          = 1'b0;
    bus.step          = 1'b0;
    bus.instr         = 16'h0000;
    bus.dec_reg_write = 1'b0;
    bus.branch_taken  = 1'b0;
    exp_halted        = 1'b0;
    exp_retired       = '0;

    repeat (2) @(posedge clk);
    #1;
    idle("reset", 1);
    reset = 1'b0;
    idle("idle", 20);

    // Free-running program LD, ADD, HLT.
    start_exec();
    run_instr("LD",  16'h0810, 1'b1, 1'b0, 8'h03, 5'b00000, 5'b00000, 1'b0);
    run_instr("ADD", 16'hC100, 1'b1, 1'b0, 8'h01, 5'b00000, 5'b00000, 1'b0);
    run_instr("HLT", 16'hC0F0, 1'b0, 1'b0, 8'h00, 5'b00000, 5'b00000, 1'b1);
    idle("halted", 3);

    // Single step on ST; a step edge landing in P3 is ignored.
    do_reset();
    idle("post_reset", 2);
    start_step();
    run_instr("ST_step", 16'h4000, 1'b0, 1'b0, 8'h04, 5'b00000, 5'b00010, 1'b0);
    idle("step_done", 3);

    // Exec edge in P2 stops after the current instruction.
    start_exec();
    run_instr("ADD_stop", 16'hC100, 1'b1, 1'b0, 8'h01, 5'b00001, 5'b00000, 1'b0);
    idle("stopped", 2);

    // Two exec edges inside one instruction cancel; the next edge stops.
    start_exec();
    run_instr("ADD_2x",   16'hC100, 1'b1, 1'b0, 8'h01, 5'b00101, 5'b00000, 1'b0);
    run_instr("ADD_last", 16'hC100, 1'b0, 1'b0, 8'h00, 5'b00001, 5'b00000, 1'b0);
    idle("stopped2", 2);

    // Exec edge coinciding with HLT's P5 is swallowed.
    start_exec();
    run_instr("HLT_exec", 16'hC0F0, 1'b0, 1'b0, 8'h00, 5'b01000, 5'b00000, 1'b1);
    idle("hlt_exec", 3);

    // Branch enables.
    start_step();
    run_instr("BR111_t",  16'hB800, 1'b0, 1'b1, 8'h08, 5'b00000, 5'b00000, 1'b0);
    start_step();
    run_instr("BR111_nt", 16'hB800, 1'b0, 1'b0, 8'h00, 5'b00000, 5'b00000, 1'b0);
    start_step();
    run_instr("BR100_t",  16'hA000, 1'b0, 1'b1, 8'h08, 5'b00000, 5'b00000, 1'b0);
    start_step();
    run_instr("BR000_t",  16'h8000, 1'b0, 1'b1, 8'h00, 5'b00000, 5'b00000, 1'b0);
    idle("br_done", 2);

    // Reset asserted during P4 of ST wins over mem_we.
    start_step();
    bus.instr         = 16'h4000;
    bus.dec_reg_write = 1'b0;
    bus.branch_taken  = 1'b0;
    exp_halted        = 1'b0;
    for (int p = 1; p <= 3; p++) begin
      push($sformatf("ST_rst.P%0d", p), p, std_en(p));
    end
    repeat (3) chk();
    reset = 1'b1;
    push("ST_rst.P4", 4, 8'h00);
    chk();
    reset       = 1'b0;
    exp_retired = '0;
    exp_halted  = 1'b0;
    idle("rst_p4", 2);

    // Retire enough instructions to wrap the counter back to zero.
    start_exec();
    for (int i = 0; i < (1 << CNT_W) - 1; i++) begin
      run_instr("ADD_wrap", 16'hC100, 1'b1, 1'b0, 8'h01, 5'b00000, 5'b00000, 1'b0);
    end
    run_instr("ADD_wrap_last", 16'hC100, 1'b1, 1'b0, 8'h01, 5'b00001, 5'b00000, 1'b0);
    idle("wrapped", 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Multi-cycle phase sequencer for the 16-bit SIMPLE processor core.
- Steps each instruction through five phases: P1 fetch, P2 decode/register read, P3 execute, P4 memory, P5 write-back.
- Emits one-cycle latch/write enables to the datapath.
- Owns run/stop/single-step control from the board exec and step inputs, and HLT handling.
- Sits beside the combinational instruction decoder; gates its RegWrite into the register file.

Parameters:
CNT_W, 16, width of retired-instruction counter (wraps modulo 2^CNT_W)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
exec  in  1  run/stop button level (already debounced); rising edge toggles run
step  in  1  single-step level; rising edge runs exactly one instruction while stopped
instr  in  16  current instruction register contents (valid from P2 onward)
dec_reg_write  in  1  RegWrite from decoder
branch_taken  in  1  datapath branch condition, valid in P3
phase  out  5  one-hot current phase {P5..P1}; 0 when stopped
running  out  1  1 while instructions are being sequenced
halted  out  1  1 after HLT retired, until next start
pc_we  out  1  PC <- PC+1 (P1)
ir_we  out  1  IR <- memory (P1)
rd_we  out  1  AR/BR operand latches (P2)
alu_we  out  1  DR/flags latch (P3)
br_we  out  1  PC <- branch target (P3, if branch)
mem_we  out  1  data memory write (P4, ST)
mdr_we  out  1  MDR latch (P4, LD)
reg_we  out  1  register-file write (P5)
retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset (synchronous, highest priority; applies mid-instruction too):
  - state=STOP, phase=0, running=0, halted=0, all *_we=0, retired=0.
  - exec/step edge-detect registers cleared to 0, so a button held through reset does not produce an edge.
- Edge detection: one register each for exec and step; an edge is a 0→1 transition between consecutive samples. All edges are registered internally, so each edge acts one cycle after the input rises.
- States: STOP, P1, P2, P3, P4, P5.
- STOP:
  - exec edge → P1, running=1, halted=0, mode=RUN.
  - Else step edge → P1, running=1, halted=0, mode=STEP.
  - Both edges in the same cycle → exec wins.
- Phases advance P1→P2→P3→P4→P5 unconditionally, one cycle each.
- At the end of P5, go to STOP (running=0) if any of the following hold; otherwise go to P1:
  - mode=STEP;
  - stop_req=1;
  - the instruction is HLT; this also sets halted=1.
- stop_req:
  - Set by an exec edge in any phase P1–P5.
  - A second exec edge before P5 completes clears it (toggle).
  - Cleared on entering STOP.
  - Never aborts the instruction in flight.
- Step edges outside STOP are ignored.
- An exec edge coinciding with HLT's P5 is consumed and ignored; the block ends in STOP with halted=1.
- Decode (uses instr, valid from P2):
  - op1=instr[15:14], op2=instr[13:11], op3=instr[7:4].
  - LD: op1=00. ST: op1=01.
  - BR: op1=10 and op2∈{100,111}.
  - HLT: op1=11 and op3=1111.
- Enables are combinational from state and registered decode, each active exactly one cycle:
  - pc_we, ir_we: P1.
  - rd_we: P2.
  - alu_we: P3.
  - br_we: P3 && BR && branch_taken.
  - mem_we: P4 && ST.
  - mdr_we: P4 && LD.
  - reg_we: P5 && dec_reg_write.
- instr=0x0000 (NOP) still takes 5 cycles; no writes occur (dec_reg_write=0).
- retired increments on every P5 exit, including HLT; it wraps from all-ones to 0.
- Restart after HLT resumes at the already-incremented PC; no PC reset occurs.
- Latency: 5 cycles per instruction. Start edge to first P1 is 2 cycles (edge register, then STOP→P1).

Decomposition:
- Shared package simple_pkg:
  - op1/op2/op3 field positions and opcode constants (LD, ST, BR, BCOND, HLT, CMP, OUT);
  - phase_t enumeration (STOP, P1..P5) and its one-hot encoding.
- No sub-module except a small edge_detect (clock, reset, level → rise pulse), instantiated twice for exec and step.

Test Plan:
- Reset then idle: running=0, phase=0, all enables 0, retired=0 for 20 cycles with exec low.
- exec edge, program LD then ADD then HLT:
  - phase sequence P1..P5 repeats three times;
  - mdr_we in the LD's P4;
  - reg_we in P5 of LD and ADD only;
  - ends with halted=1, retired=3.
- step edge while stopped on ST:
  - exactly one instruction runs, with mem_we high for one cycle in P4;
  - returns to STOP, retired=1;
  - a step edge during P3 is ignored.
- Running loop, exec edge in P2:
  - current instruction completes through P5, then STOP;
  - two exec edges within one instruction → execution continues uninterrupted.
- Branch, instr op1=10/op2=111:
  - branch_taken=1 → br_we high in P3;
  - branch_taken=0 → br_we stays 0;
  - pc_we fires in P1 in both cases.
- Reset asserted in P4 of ST → mem_we low that cycle (reset has priority), state STOP next cycle; retired wraps 0xFFFF→0x0000 after a forced-count run.
